// File: rtl/arith_ext_bist_pkg.sv
// arith_ext_bist_pkg: shared state type and constants for the extender self-test
package arith_ext_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_t;
  localparam int NUM_VEC = 16;
  localparam logic [15:0] EXT_GOLDEN = 16'hD800;
endpackage

// File: rtl/arith_ext_bist_if.sv
// arith_ext_bist_if: control, result and extender stimulus/response bundle
interface arith_ext_bist_if;
  logic start, abort, yi;
  logic M, S1, S0, bi;
  logic busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail;
  logic [15:0] resp_vec;
  modport slave (input start, abort, yi,
                 output M, S1, S0, bi, busy, done, pass, err_count, first_fail, resp_vec);
  modport master (output start, abort, yi,
                  input M, S1, S0, bi, busy, done, pass, err_count, first_fail, resp_vec);
endinterface

// File: rtl/arith_ext_bist_cmp.sv
// arith_ext_bist_cmp: captures sampled yi and tallies mismatches against the golden table
module arith_ext_bist_cmp
  import arith_ext_bist_pkg::*;
#(
  parameter logic [15:0] EXPECT = EXT_GOLDEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [3:0]  idx,
  input  logic        yi,
  output logic        miss,
  output logic [15:0] resp_vec,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail
);
  assign miss = yi != EXPECT[idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vec   <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (clr) begin
      resp_vec   <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (we) begin
      resp_vec[idx] <= yi;
      if (miss) begin
        err_count <= err_count + 5'd1;
        if (err_count == 5'd0) first_fail <= idx;
      end
    end
  end
endmodule

// File: rtl/arith_ext_bist.sv
// arith_ext_bist: sweeps all 16 {M,S1,S0,bi} vectors through the extender,
// holding each for SETTLE cycles and checking the sampled yi.
module arith_ext_bist
  import arith_ext_bist_pkg::*;
#(
  parameter int          SETTLE = 4,
  parameter logic [15:0] EXPECT = EXT_GOLDEN
) (
  input logic clk,
  input logic rst_n,
  arith_ext_bist_if.slave bus
);
  bist_state_t state, nxt;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic clr, we, sample, last_idx, miss, pass;
  assign sample   = cnt == 8'(SETTLE - 1);
  assign last_idx = idx == 4'(NUM_VEC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    clr = 1'b0;
    we  = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.abort) begin
        nxt = RUN;
        clr = 1'b1;
      end
      RUN: if (bus.abort) nxt = IDLE;
        else if (sample) begin
          we  = 1'b1;
          nxt = last_idx ? DONE : RUN;
        end
      default: nxt = IDLE;
    endcase
  end
  // pass folds in the final sample's miss so it is valid in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      pass <= 1'b0;
    end else if (clr) begin
      idx  <= '0;
      cnt  <= '0;
      pass <= 1'b0;
    end else if (state == RUN) begin
      cnt <= sample ? 8'd0 : cnt + 8'd1;
      if (we && !last_idx) idx <= idx + 4'd1;
      if (we && last_idx) pass <= (bus.err_count == 5'd0) && !miss;
    end
  end
  arith_ext_bist_cmp #(.EXPECT(EXPECT)) u_cmp (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .idx(idx), .yi(bus.yi),
    .miss(miss), .resp_vec(bus.resp_vec), .err_count(bus.err_count),
    .first_fail(bus.first_fail)
  );
  assign {bus.M, bus.S1, bus.S0, bus.bi} = state == RUN ? idx : 4'd0;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.pass = pass;
endmodule

// File: tb/tb_arith_ext_bist.sv
// tb_arith_ext_bist: scoreboard bench for the extender self-test engine
module tb_arith_ext_bist;
  import arith_ext_bist_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  arith_ext_bist_if b4();
  arith_ext_bist_if b1();
  arith_ext_bist #(.SETTLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  arith_ext_bist #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  int mode4 = 0, mode1 = 0;
  int checks = 0, errors = 0;
  typedef struct packed {logic pass; logic [4:0] err; logic [3:0] ff; logic [15:0] resp;} res_t;
  res_t sb[$];
  function automatic logic ext(input logic [3:0] i);
    logic [1:0] s;
    s = i[2:1];
    if (!i[3]) return 1'b0;
    return s == 2'd0 ? 1'b0 : s == 2'd1 ? i[0] : s == 2'd2 ? ~i[0] : 1'b1;
  endfunction
  // mode 0: good extender, 1: yi stuck at 0, 2: inverted extender
  function automatic logic resp_of(input int mode, input logic [3:0] i);
    return mode == 0 ? ext(i) : mode == 1 ? 1'b0 : ~ext(i);
  endfunction
  assign b4.yi = resp_of(mode4, {b4.M, b4.S1, b4.S0, b4.bi});
  assign b1.yi = resp_of(mode1, {b1.M, b1.S1, b1.S0, b1.bi});
  function automatic res_t model(input int mode, input int n);
    res_t r;
    logic y;
    r = '0;
    for (int i = 0; i < n; i++) begin
      y = resp_of(mode, 4'(i));
      r.resp[i] = y;
      if (y != ext(4'(i))) begin
        if (r.err == 0) r.ff = 4'(i);
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (n == 16) && (r.err == 0);
    return r;
  endfunction
  task automatic pulse4();
    @(negedge clk); b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
  endtask
  task automatic wait_done4(inout int k);
    while (!b4.done && k < 200) begin @(negedge clk); k++; end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b4.busy, b4.done, b4.pass, b4.err_count, b4.first_fail, b4.resp_vec, b4.M, b4.S1, b4.S0, b4.bi} !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b pass=%b err=%0d ff=%0d resp=%h stim=%b%b%b%b want all zero",
               b4.busy, b4.done, b4.pass, b4.err_count, b4.first_fail, b4.resp_vec, b4.M, b4.S1, b4.S0, b4.bi);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_run(input int mode, input string name);
    int k;
    res_t e, got;
    mode4 = mode;
    sb.push_back(model(mode, 16));
    pulse4();
    k = 1;
    checks++;
    if ({b4.busy, b4.M, b4.S1, b4.S0, b4.bi} !== 5'b10000) begin
      errors++;
      $display("FAIL %s_first_cycle got busy=%b stim=%b%b%b%b want busy=1 stim=0000", name, b4.busy, b4.M, b4.S1, b4.S0, b4.bi);
    end
    wait_done4(k);
    checks++;
    if (k !== 65 || b4.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_time got cycle %0d done=%b want cycle 65 done=1", name, k, b4.done);
    end
    e = sb.pop_front();
    got = {b4.pass, b4.err_count, b4.first_fail, b4.resp_vec};
    checks++;
    if (got.pass !== e.pass || got.err !== e.err || got.resp !== e.resp || (e.err != 0 && got.ff !== e.ff)) begin
      errors++;
      $display("FAIL %s_result got pass=%b err=%0d ff=%0d resp=%h want pass=%b err=%0d ff=%0d resp=%h",
               name, got.pass, got.err, got.ff, got.resp, e.pass, e.err, e.ff, e.resp);
    end
    @(negedge clk);
    checks++;
    if ({b4.done, b4.busy, b4.pass, b4.err_count, b4.resp_vec} !== {2'b00, e.pass, e.err, e.resp}) begin
      errors++;
      $display("FAIL %s_hold got done=%b busy=%b pass=%b err=%0d resp=%h want done=0 busy=0 pass=%b err=%0d resp=%h",
               name, b4.done, b4.busy, b4.pass, b4.err_count, b4.resp_vec, e.pass, e.err, e.resp);
    end
  endtask
  task automatic test_abort();
    int k;
    bit seen;
    res_t e;
    mode4 = 2;
    pulse4();
    k = 1;
    repeat (19) @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    checks++;
    if ({b4.busy, b4.M, b4.S1, b4.S0, b4.bi} !== 5'b10101) begin
      errors++;
      $display("FAIL restart_ignored got busy=%b stim=%b%b%b%b want busy=1 stim=0101", b4.busy, b4.M, b4.S1, b4.S0, b4.bi);
    end
    repeat (9) @(negedge clk);
    b4.abort = 1'b1;
    @(negedge clk); b4.abort = 1'b0;
    e = model(2, 7);
    checks++;
    if ({b4.busy, b4.done, b4.pass, b4.M, b4.S1, b4.S0, b4.bi} !== 7'd0 || b4.err_count !== e.err || b4.resp_vec !== e.resp) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b pass=%b stim=%b%b%b%b err=%0d resp=%h want zeros err=%0d resp=%h",
               b4.busy, b4.done, b4.pass, b4.M, b4.S1, b4.S0, b4.bi, b4.err_count, b4.resp_vec, e.err, e.resp);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); seen |= b4.done | b4.busy; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got done/busy seen=%b want 0", seen);
    end
    b4.start = 1'b1; b4.abort = 1'b1;
    @(negedge clk); b4.start = 1'b0; b4.abort = 1'b0;
    seen = b4.busy;
    repeat (3) begin @(negedge clk); seen |= b4.busy; end
    checks++;
    if (seen !== 1'b0 || b4.err_count !== e.err) begin
      errors++;
      $display("FAIL start_abort_idle got busy_seen=%b err=%0d want busy_seen=0 err=%0d", seen, b4.err_count, e.err);
    end
  endtask
  task automatic test_reset_mid();
    mode4 = 2;
    pulse4();
    repeat (39) @(negedge clk);
    checks++;
    if (b4.err_count === 5'd0) begin
      errors++;
      $display("FAIL pre_reset_errs got err=0 want nonzero");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b4.busy, b4.done, b4.pass, b4.err_count, b4.first_fail, b4.resp_vec, b4.M, b4.S1, b4.S0, b4.bi} !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b pass=%b err=%0d ff=%0d resp=%h stim=%b%b%b%b want all zero",
               b4.busy, b4.done, b4.pass, b4.err_count, b4.first_fail, b4.resp_vec, b4.M, b4.S1, b4.S0, b4.bi);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_run(0, "post_reset");
  endtask
  task automatic test_settle1();
    int k;
    res_t e;
    mode1 = 0;
    sb.push_back(model(0, 16));
    @(negedge clk); b1.start = 1'b1;
    @(negedge clk); b1.start = 1'b0;
    k = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({b1.busy, b1.M, b1.S1, b1.S0, b1.bi} !== {1'b1, 4'(i)}) begin
        errors++;
        $display("FAIL settle1_stim[%0d] got busy=%b stim=%b%b%b%b want busy=1 stim=%b", i, b1.busy, b1.M, b1.S1, b1.S0, b1.bi, 4'(i));
      end
      @(negedge clk); k++;
    end
    while (!b1.done && k < 100) begin @(negedge clk); k++; end
    e = sb.pop_front();
    checks++;
    if (k !== 17 || b1.pass !== e.pass || b1.err_count !== e.err || b1.resp_vec !== e.resp) begin
      errors++;
      $display("FAIL settle1_done got cycle=%0d pass=%b err=%0d resp=%h want cycle=17 pass=%b err=%0d resp=%h",
               k, b1.pass, b1.err_count, b1.resp_vec, e.pass, e.err, e.resp);
    end
  endtask
  initial begin
    b4.start = 1'b0; b4.abort = 1'b0;
    b1.start = 1'b0; b1.abort = 1'b0;
    test_reset();
    test_run(0, "good");
    test_run(1, "yi_zero");
    test_run(2, "inverted");
    test_abort();
    test_reset_mid();
    test_settle1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
